// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the div_share_sched divider-sharing scheduler:
//   - state_t : scheduler state encoding (IDLE/START/WAIT/DONE)
//   - DEF_WIDTH, DEF_TIMEOUT : default operand width and WAIT-state cycle limit
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin picker, purely combinational.
// Ports:
//   eligible [1:0] in  : requesters that may be granted this cycle
//   rr             in  : requester that wins when both are eligible
//   grant    [1:0] out : one-hot grant (all zero when nobody is eligible)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       rr,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: every output gets a value before any branch, so no latch is inferred.
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = rr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/div_share_sched.sv
// -----------------------------------------------------------------------------
// div_share_sched
// Shares one divider datapath between two requesters. Single-cycle requests
// are captured into pending bits, arbitrated round-robin in IDLE, and the
// winner's operands are latched and handed to the divider with a one-cycle
// start strobe. The result (or a timeout error) is returned to the winner
// with a one-cycle done pulse.
//
// Optional feature (macro DIV_SHARE_ZERO_BYPASS_EN): a zero divisor skips the
// divider and completes immediately with quotient = all ones,
// remainder = dividend, err = 1.
//
// Ports:
//   clk, reset                 : clock (rising edge), async active-low reset
//   req0/req1                  : request pulses from requester 0/1
//   dividend0/1, divisor0/1    : operands, stable from request until done
//   done0/done1                : one-cycle result pulse to requester 0/1
//   quotient, remainder, err   : registered result, qualified by doneN
//   busy                       : scheduler is not in IDLE
//   div_start                  : one-cycle start strobe to the divider
//   div_dividend, div_divisor  : latched operands driven to the divider
//   div_valid, div_quotient,
//   div_remainder              : divider result handshake
// -----------------------------------------------------------------------------
module div_share_sched
    import div_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] dividend0,
    input  logic [WIDTH-1:0] dividend1,
    input  logic [WIDTH-1:0] divisor0,
    input  logic [WIDTH-1:0] divisor1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             err,
    output logic             busy,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_pend;
    logic             r_rr;
    logic             r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_err;

    logic [1:0]       w_req;
    logic [1:0]       w_eligible;
    logic [1:0]       w_grant;
    logic [1:0]       w_take;
    logic [1:0]       w_serving;
    logic             w_grant_any;
    logic [WIDTH-1:0] w_sel_dividend;
    logic [WIDTH-1:0] w_sel_divisor;
    logic             w_zero_bypass;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;

    // ---------------------------------------------------------------------
    // Arbitration: a request arriving in IDLE is eligible in the same cycle.
    // ---------------------------------------------------------------------
    assign w_req      = {req1, req0};
    assign w_eligible = r_pend | w_req;

    rr_arb2 u_arb (
        .eligible (w_eligible),
        .rr       (r_rr),
        .grant    (w_grant)
    );

    assign w_grant_any    = (r_state == IDLE) && (|w_grant);
    assign w_take         = (r_state == IDLE) ? w_grant : 2'b00;
    // The owner is "being served" from grant until the DONE cycle inclusive.
    assign w_serving      = busy ? {r_owner, ~r_owner} : 2'b00;
    assign w_sel_dividend = w_grant[1] ? dividend1 : dividend0;
    assign w_sel_divisor  = w_grant[1] ? divisor1  : divisor0;

`ifdef DIV_SHARE_ZERO_BYPASS_EN
    assign w_zero_bypass = (w_sel_divisor == '0);
`else
    assign w_zero_bypass = 1'b0;
`endif

    // The counter holds k-1 in the k-th WAIT cycle; aborting when the
    // incremented value reaches TIMEOUT-1 lands DONE exactly TIMEOUT cycles
    // after START (with at least one WAIT cycle for TIMEOUT=1).
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (w_cnt_inc >= CNT_LAST);

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_any) begin
                    w_state_nxt = w_zero_bypass ? DONE : START;
                end
            end
            START: w_state_nxt = WAIT;
            WAIT: begin
                if (div_valid || w_timeout) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Pending request bits: one slot per requester, no deeper queueing.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_take[i]) begin
                    r_pend[i] <= 1'b0;
                end else if (w_req[i] && !w_serving[i]) begin
                    r_pend[i] <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Operand, result, owner, round-robin pointer and timeout counter.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner    <= 1'b0;
            r_rr       <= 1'b0;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_owner    <= w_grant[1];
                        r_dividend <= w_sel_dividend;
                        r_divisor  <= w_sel_divisor;
                        if (w_zero_bypass) begin
                            r_quot <= '1;
                            r_rem  <= w_sel_dividend;
                            r_err  <= 1'b1;
                        end
                    end
                end
                START: r_cnt <= '0;
                WAIT: begin
                    r_cnt <= w_cnt_inc;
                    // A divider result arriving on the timeout cycle still wins.
                    if (div_valid) begin
                        r_quot <= div_quotient;
                        r_rem  <= div_remainder;
                        r_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_quot <= '0;
                        r_rem  <= '0;
                        r_err  <= 1'b1;
                    end
                end
                DONE:    r_rr <= ~r_owner;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign busy         = (r_state != IDLE);
    assign div_start    = (r_state == START);
    assign done0        = (r_state == DONE) && !r_owner;
    assign done1        = (r_state == DONE) &&  r_owner;
    assign quotient     = r_quot;
    assign remainder    = r_rem;
    assign err          = r_err;
    assign div_dividend = r_dividend;
    assign div_divisor  = r_divisor;

endmodule

// File: tb/tb_div_share_sched.sv
`timescale 1ns/1ps
module tb_div_share_sched;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req0 = 1'b0;
    logic             req1 = 1'b0;
    logic [WIDTH-1:0] dividend0 = '0;
    logic [WIDTH-1:0] dividend1 = '0;
    logic [WIDTH-1:0] divisor0 = '0;
    logic [WIDTH-1:0] divisor1 = '0;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             err;
    logic             busy;
    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_valid = 1'b0;
    logic [WIDTH-1:0] div_quotient = '0;
    logic [WIDTH-1:0] div_remainder = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int model_lat = 0;   // divider model latency after start; 0 = never valid
    bit stray    = 1'b0; // request one stray div_valid cycle
    int model_rr = 0;    // requester that wins the next simultaneous pair

    div_share_sched #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req0          (req0),
        .req1          (req1),
        .dividend0     (dividend0),
        .dividend1     (dividend1),
        .divisor0      (divisor0),
        .divisor1      (divisor1),
        .done0         (done0),
        .done1         (done1),
        .quotient      (quotient),
        .remainder     (remainder),
        .err           (err),
        .busy          (busy),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_valid     (div_valid),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Behavioural divider: valid for one cycle model_lat cycles after start.
    initial begin : divider_model
        int         cd;
        logic [7:0] a;
        logic [7:0] b;
        cd = 0;
        a  = '0;
        b  = '0;
        forever begin
            @(negedge clk);
            div_valid = 1'b0;
            if (!reset) begin
                cd = 0;
            end else begin
                if (stray) begin
                    div_valid     = 1'b1;
                    div_quotient  = 8'hAA;
                    div_remainder = 8'h55;
                    stray         = 1'b0;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        div_valid = 1'b1;
                        if (b == 0) begin
                            div_quotient  = 8'hFF;
                            div_remainder = a;
                        end else begin
                            div_quotient  = a / b;
                            div_remainder = a % b;
                        end
                    end
                end
                if (div_start && model_lat > 0) begin
                    cd = model_lat;
                    a  = div_dividend;
                    b  = div_divisor;
                end
            end
        end
    end

    task automatic drive_req(input int id, input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin
            dividend0 = a;
            divisor0  = b;
            req0      = 1'b1;
        end else begin
            dividend1 = a;
            divisor1  = b;
            req1      = 1'b1;
        end
    endtask

    // Bounded wait at negedges; which: 0=done0, 1=done1, 2=div_start.
    task automatic wait_ev(input int which, input int max_cyc, output int at, output bit got);
        got = 1'b0;
        at  = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if ((which == 0 && done0 === 1'b1) || (which == 1 && done1 === 1'b1) ||
                (which == 2 && div_start === 1'b1)) begin
                got = 1'b1;
                at  = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int  at;
        bit  got;
        bit  bad;
        logic [47:0] vec;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vec = {done0, done1, busy, div_start, err, 3'b000, quotient, remainder, div_dividend, div_divisor};
        n_checks++;
        if (vec !== '0) begin
            n_errors++;
            $display("FAIL reset_initial: outputs %h expected 0", vec);
        end
        reset = 1'b1;
        @(negedge clk);
        model_lat = 0;
        drive_req(0, 8'd50, 8'd3);
        @(negedge clk);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        drive_req(1, 8'd9, 8'd2);
        @(negedge clk);
        req1 = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || div_dividend !== 8'd50) begin
            n_errors++;
            $display("FAIL reset_pre_busy: busy=%b div_dividend=%0d expected 1/50", busy, div_dividend);
        end
        #1 reset = 1'b0;
        #1;
        vec = {done0, done1, busy, div_start, err, 3'b000, quotient, remainder, div_dividend, div_divisor};
        n_checks++;
        if (vec !== '0) begin
            n_errors++;
            $display("FAIL reset_async: outputs %h expected 0", vec);
        end
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL reset_drop_pending: activity after reset, expected idle");
        end
        model_rr  = 0;
        model_lat = 5;
        drive_req(1, 8'd9, 8'd2);
        @(negedge clk);
        req1 = 1'b0;
        wait_ev(1, 40, at, got);
        n_checks++;
        if (!got || quotient !== 8'd4 || remainder !== 8'd1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_after_op: got=%b q=%0d r=%0d err=%b expected 1/4/1/0", got, quotient, remainder, err);
        end
        model_rr = 0;
        @(negedge clk);
    endtask

    task automatic test_single(input int id, input logic [7:0] a, input logic [7:0] b,
                               input int lat, input string name);
        int         t;
        int         at;
        bit         got;
        logic [7:0] eq;
        logic [7:0] er;
        eq = a / b;
        er = a % b;
        model_lat = lat;
        @(negedge clk);
        drive_req(id, a, b);
        t = cyc;
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        n_checks++;
        if (div_start !== 1'b1 || div_dividend !== a || div_divisor !== b) begin
            n_errors++;
            $display("FAIL %s_start: start=%b dd=%0d ds=%0d expected 1/%0d/%0d", name, div_start, div_dividend, div_divisor, a, b);
        end
        wait_ev(id, lat + 10, at, got);
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL %s_done: no done%0d seen, expected one", name, id);
        end else begin
            n_checks++;
            if (at !== t + lat + 2) begin
                n_errors++;
                $display("FAIL %s_latency: done at cycle %0d expected %0d", name, at, t + lat + 2);
            end
            n_checks++;
            if (quotient !== eq || remainder !== er || err !== 1'b0) begin
                n_errors++;
                $display("FAIL %s_result: q=%0d r=%0d err=%b expected %0d/%0d/0", name, quotient, remainder, err, eq, er);
            end
            n_checks++;
            if ((id == 0 && done1 !== 1'b0) || (id == 1 && done0 !== 1'b0)) begin
                n_errors++;
                $display("FAIL %s_other_done: done0=%b done1=%b expected only done%0d", name, done0, done1, id);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_pulse: done0=%b done1=%b busy=%b expected 0/0/0", name, done0, done1, busy);
        end
        model_rr = 1 - id;
    endtask

    task automatic test_contention_pair(input int lat);
        logic [7:0] a[2];
        logic [7:0] b[2];
        int         first;
        int         second;
        int         t;
        int         at;
        int         at2;
        int         at3;
        bit         got;
        for (int i = 0; i < 2; i++) begin
            a[i] = 8'($urandom);
            b[i] = 8'($urandom_range(1, 255));
        end
        first     = model_rr;
        second    = 1 - first;
        model_lat = lat;
        @(negedge clk);
        drive_req(0, a[0], b[0]);
        drive_req(1, a[1], b[1]);
        t = cyc;
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        n_checks++;
        if (div_start !== 1'b1 || div_dividend !== a[first] || div_divisor !== b[first]) begin
            n_errors++;
            $display("FAIL contention_first_grant: start=%b dd=%0d expected 1/%0d (req%0d)", div_start, div_dividend, a[first], first);
        end
        wait_ev(first, lat + 10, at, got);
        n_checks++;
        if (!got || at !== t + lat + 2 || quotient !== a[first] / b[first] || remainder !== a[first] % b[first]) begin
            n_errors++;
            $display("FAIL contention_first_done: got=%b at=%0d q=%0d r=%0d expected cycle %0d q=%0d r=%0d",
                     got, at, quotient, remainder, t + lat + 2, a[first] / b[first], a[first] % b[first]);
        end
        model_rr = second;
        wait_ev(2, 6, at2, got);
        n_checks++;
        if (!got || at2 !== at + 2 || div_dividend !== a[second] || div_divisor !== b[second]) begin
            n_errors++;
            $display("FAIL contention_second_grant: got=%b at=%0d dd=%0d expected cycle %0d dd=%0d", got, at2, div_dividend, at + 2, a[second]);
        end
        wait_ev(second, lat + 10, at3, got);
        n_checks++;
        if (!got || at3 !== at2 + lat + 1 || quotient !== a[second] / b[second] || remainder !== a[second] % b[second]) begin
            n_errors++;
            $display("FAIL contention_second_done: got=%b at=%0d q=%0d r=%0d expected cycle %0d q=%0d r=%0d",
                     got, at3, quotient, remainder, at2 + lat + 1, a[second] / b[second], a[second] % b[second]);
        end
        model_rr = first;
        @(negedge clk);
    endtask

    task automatic test_contention();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        model_rr = 0;
        test_contention_pair($urandom_range(1, 12));
        test_contention_pair($urandom_range(1, 12));
    endtask

    task automatic test_queue();
        int t;
        int at0;
        int as;
        int at1;
        int extra;
        bit got;
        model_lat = 10;
        @(negedge clk);
        drive_req(0, 8'd200, 8'd9);
        t = cyc;
        @(negedge clk);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        drive_req(1, 8'd77, 8'd5);
        req0 = 1'b1;          // requester 0 re-requests while being served
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        req1 = 1'b1;          // duplicate while pending
        @(negedge clk);
        req1 = 1'b0;
        wait_ev(0, 20, at0, got);
        n_checks++;
        if (!got || at0 !== t + 12 || quotient !== 8'd22 || remainder !== 8'd2) begin
            n_errors++;
            $display("FAIL queue_done0: got=%b at=%0d q=%0d r=%0d expected cycle %0d q=22 r=2", got, at0, quotient, remainder, t + 12);
        end
        wait_ev(2, 6, as, got);
        n_checks++;
        if (!got || as !== at0 + 2 || div_dividend !== 8'd77) begin
            n_errors++;
            $display("FAIL queue_grant1: got=%b at=%0d dd=%0d expected cycle %0d dd=77", got, as, div_dividend, at0 + 2);
        end
        wait_ev(1, 20, at1, got);
        n_checks++;
        if (!got || at1 !== as + 11 || quotient !== 8'd15 || remainder !== 8'd2) begin
            n_errors++;
            $display("FAIL queue_done1: got=%b at=%0d q=%0d r=%0d expected cycle %0d q=15 r=2", got, at1, quotient, remainder, as + 11);
        end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done0 === 1'b1 || done1 === 1'b1 || div_start === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_errors++;
            $display("FAIL queue_no_duplicate: %0d extra events expected 0", extra);
        end
        model_rr = 0;
    endtask

    task automatic test_timeout();
        int t;
        int at;
        bit got;
        bit bad;
        model_lat = 0;
        @(negedge clk);
        drive_req(0, 8'd123, 8'd4);
        t = cyc;
        @(negedge clk);
        req0 = 1'b0;
        wait_ev(0, TIMEOUT + 20, at, got);
        n_checks++;
        if (!got || at !== t + 1 + TIMEOUT) begin
            n_errors++;
            $display("FAIL timeout_latency: got=%b at=%0d expected cycle %0d", got, at, t + 1 + TIMEOUT);
        end
        n_checks++;
        if (quotient !== 8'd0 || remainder !== 8'd0 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_result: q=%0d r=%0d err=%b expected 0/0/1", quotient, remainder, err);
        end
        model_rr = 1;
        @(posedge clk);
        stray = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad || quotient !== 8'd0 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_stray_valid: activity=%b q=%0d err=%b expected 0/0/1", bad, quotient, err);
        end
    endtask

    task automatic test_zero_divisor();
        int t;
        int at;
        bit got;
        model_lat = 3;
        @(negedge clk);
        drive_req(0, 8'd37, 8'd0);
        t = cyc;
        @(negedge clk);
        req0 = 1'b0;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
        n_checks++;
        if (div_start !== 1'b0 || done0 !== 1'b1 || quotient !== 8'hFF || remainder !== 8'd37 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_bypass: start=%b done0=%b q=%h r=%0d err=%b expected 0/1/ff/37/1",
                     div_start, done0, quotient, remainder, err);
        end
        @(negedge clk);
`else
        n_checks++;
        if (div_start !== 1'b1 || div_divisor !== 8'd0) begin
            n_errors++;
            $display("FAIL zero_start: start=%b ds=%0d expected 1/0", div_start, div_divisor);
        end
        wait_ev(0, 15, at, got);
        n_checks++;
        if (!got || at !== t + 5 || quotient !== 8'hFF || remainder !== 8'd37 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_passthrough: got=%b at=%0d q=%h r=%0d err=%b expected cycle %0d ff/37/0",
                     got, at, quotient, remainder, err, t + 5);
        end
        @(negedge clk);
`endif
        model_rr = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            test_single($urandom_range(0, 1), 8'($urandom), 8'($urandom_range(1, 255)),
                        $urandom_range(1, 20), "random");
        end
    endtask

    initial begin
        test_reset();
        test_single(0, 8'd100, 8'd7, 9, "single");
        test_contention();
        test_queue();
        test_timeout();
        test_single(1, 8'd250, 8'd3, TIMEOUT - 1, "valid_timeout_tie");
        test_zero_divisor();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
